lc4_nzp_branch_unit: RTL and testbench
======================================

// Module: lc4_nzp_branch_unit
// PURPOSE
//  Consumer end of the ALU result path: tracks the LC4 NZP condition register from writeback results.
//  Resolves BR instructions against NZP and emits a redirect PC (taken: PC+1+sext(IMM9), else PC+1).
//  A pending-writer scoreboard stalls branch resolution until every in-flight NZP writer has written back.
//  Sits between ALU/writeback and the fetch-redirect logic.
// PARAMETERS
//  MAX_PENDING  7  max in-flight NZP writers tracked; counter width = $clog2(MAX_PENDING+1)
// PORTS
//  clk              in   1   single clock, rising edge
//  rst_n            in   1   asynchronous, active-low reset
//  i_issue_valid    in   1   an NZP-writing insn issued this cycle (pending++)
//  o_issue_stall    out  1   pending == MAX_PENDING; issuer must hold i_issue_valid low
//  i_wb_valid       in   1   writeback beat valid
//  i_wb_nzp_we      in   1   writeback updates NZP (pending--)
//  i_wb_result      in   16  value written back; NZP derived from it
//  i_br_valid       in   1   branch request valid
//  o_br_ready       out  1   unit can accept a branch (state IDLE)
//  i_br_insn        in   16  branch instruction word
//  i_br_pc          in   16  PC of branch
//  o_redirect_valid out  1   one-cycle pulse: resolution available
//  o_redirect_taken out  1   branch taken (valid with o_redirect_valid)
//  o_redirect_pc    out  16  next PC (valid with o_redirect_valid)
//  o_nzp            out  3   current NZP {N,Z,P}
//  o_pending        out  W   in-flight NZP writer count
//  o_err            out  1   sticky: underflow or issue while stalled
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, NZP=3'b010, pending=0, o_err=0, o_redirect_*=0, captured insn/pc=0.
//  Reset mid-operation drops any held branch without emitting a redirect.
//  NZP update: on i_wb_valid&i_wb_nzp_we, next-edge NZP = 100 if result[15], 010 if result==0, else 001.
//  Pending: +1 on i_issue_valid, -1 on wb write; both same cycle -> unchanged.
//  Pending boundaries: decrement at 0 ignored, sets o_err; increment at MAX_PENDING ignored, sets o_err.
//  FSM IDLE: o_br_ready=1; on i_br_valid capture insn/pc; next = RESOLVE if pending_next==0 else WAIT.
//  FSM WAIT: o_br_ready=0; go RESOLVE on the edge where pending_next==0; stay otherwise.
//  FSM RESOLVE: o_br_ready=0; o_redirect_valid=1 for exactly this cycle; always -> IDLE.
//  Resolution (combinational from registers in RESOLVE): taken = (insn[15:12]==4'h0) & |(insn[11:9] & NZP).
//  Target: taken ? pc+1+sext(insn[8:0]) : pc+1; 16-bit arithmetic, wraps modulo 2^16.
//  Non-BR opcode is accepted and resolves not-taken; insn[11:9]==000 (NOP) resolves not-taken.
//  Latency: accept at edge E with no pending -> o_redirect_valid high in cycle after E; throughput 1 branch / 2 cycles.
//  A wb write on the accept edge is visible to that branch (RESOLVE reads the updated NZP).
// CONFIGURATION
//  LC4_BR_STATS_EN defined: adds outputs o_stat_resolved[15:0] and o_stat_taken[15:0].
//  Counters reset to 0, +1 on each RESOLVE cycle (taken count only when taken), wrap at 16'hFFFF->0.
//  LC4_BR_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package lc4_br_pkg: FSM state encodings (IDLE/WAIT/RESOLVE), OPC_BR=4'h0, NZP_N/NZP_Z/NZP_P, NZP reset value.
//  Sub-module lc4_nzp_gen: 16-bit result -> 3-bit one-hot NZP (combinational); used for the wb update.
// TESTING
//  Reset: hold rst_n=0 mid-WAIT -> o_nzp=010, pending=0, o_br_ready=1, no redirect pulse after release.
//  wb result 16'h8000, then BR n (insn 16'h0805, pc 16'h0100) -> taken=1, o_redirect_pc=16'h0106 one cycle after accept.
//  wb result 16'h0000, then BRp (insn 16'h0203, pc 16'hFFFF) -> taken=0, o_redirect_pc=16'h0000 (wrap).
//  Issue x2, then BRz accept -> stays WAIT; two wb writes (last 0) -> RESOLVE next edge, taken=1.
//  Issue and wb write same cycle at pending=1 -> pending stays 1; wb with pending=0 -> o_err=1, sticky.
//  Fill pending to MAX_PENDING -> o_issue_stall=1; under LC4_BR_STATS_EN, 3 branches (2 taken) -> stats 3/2.

Source files
------------

// File: rtl/lc4_br_pkg.sv
// Shared definitions for the LC4 NZP branch unit: FSM states, BR opcode,
// and the one-hot NZP encodings with their reset value.
package lc4_br_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESOLVE = 2'd2
    } br_state_t;

    localparam logic [3:0] OPC_BR    = 4'h0;
    localparam logic [2:0] NZP_N     = 3'b100;
    localparam logic [2:0] NZP_Z     = 3'b010;
    localparam logic [2:0] NZP_P     = 3'b001;
    localparam logic [2:0] NZP_RESET = NZP_Z;

endpackage

// File: rtl/lc4_nzp_gen.sv
// Maps a 16-bit two's-complement result onto the one-hot LC4 NZP code.
module lc4_nzp_gen
    import lc4_br_pkg::*;
(
    input  logic [15:0] result,
    output logic [2:0]  nzp
);

    always_comb begin
        if (result[15])
            nzp = NZP_N;
        else if (result == 16'h0000)
            nzp = NZP_Z;
        else
            nzp = NZP_P;
    end

endmodule

// File: rtl/lc4_nzp_branch_unit.sv
// LC4 NZP tracker and BR resolver with a pending-writer scoreboard.
// Optional statistics counters are enabled by defining LC4_BR_STATS_EN.
module lc4_nzp_branch_unit
    import lc4_br_pkg::*;
#(
    parameter int unsigned MAX_PENDING = 7,
    localparam int unsigned W = $clog2(MAX_PENDING + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_issue_valid,
    output logic         o_issue_stall,
    input  logic         i_wb_valid,
    input  logic         i_wb_nzp_we,
    input  logic [15:0]  i_wb_result,
    input  logic         i_br_valid,
    output logic         o_br_ready,
    input  logic [15:0]  i_br_insn,
    input  logic [15:0]  i_br_pc,
    output logic         o_redirect_valid,
    output logic         o_redirect_taken,
    output logic [15:0]  o_redirect_pc,
    output logic [2:0]   o_nzp,
    output logic [W-1:0] o_pending,
    output logic         o_err
`ifdef LC4_BR_STATS_EN
    ,
    output logic [15:0]  o_stat_resolved,
    output logic [15:0]  o_stat_taken
`endif
);

    localparam logic [W-1:0] PEND_MAX = W'(MAX_PENDING);

    br_state_t   state;
    logic [2:0]  nzp;
    logic [2:0]  wb_nzp;
    logic [W-1:0] pending;
    logic [W-1:0] pending_next;
    logic        pend_err;
    logic        err;
    logic [15:0] br_insn;
    logic [15:0] br_pc;
    logic        wb_write;
    logic        resolving;
    logic        br_taken;
    logic [15:0] seq_pc;
    logic [15:0] target_pc;

    lc4_nzp_gen u_nzp_gen (
        .result (i_wb_result),
        .nzp    (wb_nzp)
    );

    assign wb_write = i_wb_valid & i_wb_nzp_we;

    // Simultaneous issue and writeback cancel, so neither boundary check applies.
    always_comb begin
        pending_next = pending;
        pend_err     = 1'b0;
        if (i_issue_valid && !wb_write) begin
            if (pending == PEND_MAX)
                pend_err = 1'b1;
            else
                pending_next = pending + 1'b1;
        end else if (!i_issue_valid && wb_write) begin
            if (pending == '0)
                pend_err = 1'b1;
            else
                pending_next = pending - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzp     <= NZP_RESET;
            pending <= '0;
            err     <= 1'b0;
        end else begin
            if (wb_write)
                nzp <= wb_nzp;
            pending <= pending_next;
            if (pend_err)
                err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            br_insn <= '0;
            br_pc   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_br_valid) begin
                        br_insn <= i_br_insn;
                        br_pc   <= i_br_pc;
                        state   <= (pending_next == '0) ? ST_RESOLVE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (pending_next == '0)
                        state <= ST_RESOLVE;
                end
                ST_RESOLVE: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Resolution reads NZP in the RESOLVE cycle, so a writeback on the accept edge is seen.
    assign resolving = (state == ST_RESOLVE);
    assign br_taken  = (br_insn[15:12] == OPC_BR) && |(br_insn[11:9] & nzp);
    assign seq_pc    = br_pc + 16'd1;
    assign target_pc = seq_pc + {{7{br_insn[8]}}, br_insn[8:0]};

    assign o_redirect_valid = resolving;
    assign o_redirect_taken = resolving & br_taken;
    assign o_redirect_pc    = resolving ? (br_taken ? target_pc : seq_pc) : '0;
    assign o_br_ready       = (state == ST_IDLE);
    assign o_issue_stall    = (pending == PEND_MAX);
    assign o_nzp            = nzp;
    assign o_pending        = pending;
    assign o_err            = err;

`ifdef LC4_BR_STATS_EN
    logic [15:0] stat_resolved;
    logic [15:0] stat_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved <= '0;
            stat_taken    <= '0;
        end else if (resolving) begin
            stat_resolved <= stat_resolved + 16'd1;
            if (br_taken)
                stat_taken <= stat_taken + 16'd1;
        end
    end

    assign o_stat_resolved = stat_resolved;
    assign o_stat_taken    = stat_taken;
`endif

endmodule

// File: tb/tb_lc4_nzp_branch_unit.sv
// Directed plus randomized bench for lc4_nzp_branch_unit against an arithmetic model.
module tb_lc4_nzp_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_issue_valid;
    logic        o_issue_stall;
    logic        i_wb_valid;
    logic        i_wb_nzp_we;
    logic [15:0] i_wb_result;
    logic        i_br_valid;
    logic        o_br_ready;
    logic [15:0] i_br_insn;
    logic [15:0] i_br_pc;
    logic        o_redirect_valid;
    logic        o_redirect_taken;
    logic [15:0] o_redirect_pc;
    logic [2:0]  o_nzp;
    logic [2:0]  o_pending;
    logic        o_err;
`ifdef LC4_BR_STATS_EN
    logic [15:0] o_stat_resolved;
    logic [15:0] o_stat_taken;
`endif

    int checks = 0;
    int errors = 0;
    int nzp_m = 2;
    int exp_resolved = 0;
    int exp_taken = 0;

    lc4_nzp_branch_unit #(.MAX_PENDING(7)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_issue_valid    (i_issue_valid),
        .o_issue_stall    (o_issue_stall),
        .i_wb_valid       (i_wb_valid),
        .i_wb_nzp_we      (i_wb_nzp_we),
        .i_wb_result      (i_wb_result),
        .i_br_valid       (i_br_valid),
        .o_br_ready       (o_br_ready),
        .i_br_insn        (i_br_insn),
        .i_br_pc          (i_br_pc),
        .o_redirect_valid (o_redirect_valid),
        .o_redirect_taken (o_redirect_taken),
        .o_redirect_pc    (o_redirect_pc),
        .o_nzp            (o_nzp),
        .o_pending        (o_pending),
        .o_err            (o_err)
`ifdef LC4_BR_STATS_EN
        ,
        .o_stat_resolved  (o_stat_resolved),
        .o_stat_taken     (o_stat_taken)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nzp_of(input int r);
        if (r >= 32768) return 4;
        if (r == 0) return 2;
        return 1;
    endfunction

    task automatic issue_n(input int n);
        for (int i = 0; i < n; i++) begin
            i_issue_valid = 1'b1;
            tick();
        end
        i_issue_valid = 1'b0;
    endtask

    task automatic wb(input logic [15:0] r);
        i_wb_valid = 1'b1; i_wb_nzp_we = 1'b1; i_wb_result = r;
        tick();
        i_wb_valid = 1'b0; i_wb_nzp_we = 1'b0;
        nzp_m = nzp_of(int'(r));
    endtask

    // Expected outcome from LC4 rules: BR opcode 0, mask bits against NZP, signed 9-bit offset.
    task automatic check_redirect(input string tag, input logic [15:0] insn, input logic [15:0] pc);
        int op, mask, imm, tgt;
        bit tk;
        op   = int'(insn) / 4096;
        mask = (int'(insn) / 512) % 8;
        imm  = int'(insn) % 512;
        if (imm >= 256) imm = imm - 512;
        tk   = (op == 0) && ((mask & nzp_m) != 0);
        tgt  = tk ? (int'(pc) + 1 + imm) : (int'(pc) + 1);
        tgt  = ((tgt % 65536) + 65536) % 65536;
        chk({tag, "_valid"}, 16'(o_redirect_valid), 16'd1);
        chk({tag, "_taken"}, 16'(o_redirect_taken), 16'(tk));
        chk({tag, "_pc"}, o_redirect_pc, 16'(tgt));
        exp_resolved++;
        if (tk) exp_taken++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        nzp_m = 2;
        exp_resolved = 0;
        exp_taken = 0;
        tick();
    endtask

    initial begin
        logic [15:0] insn, pc, r;
        int k;

        rst_n = 1'b0;
        i_issue_valid = 1'b0; i_wb_valid = 1'b0; i_wb_nzp_we = 1'b0; i_wb_result = '0;
        i_br_valid = 1'b0; i_br_insn = '0; i_br_pc = '0;
        tick();
        tick();
        chk("rst_nzp", 16'(o_nzp), 16'h0002);
        chk("rst_pending", 16'(o_pending), 16'h0000);
        chk("rst_ready", 16'(o_br_ready), 16'h0001);
        chk("rst_rv", 16'(o_redirect_valid), 16'h0000);
        chk("rst_rpc", o_redirect_pc, 16'h0000);
        chk("rst_err", 16'(o_err), 16'h0000);
        rst_n = 1'b1;
        tick();

        // Reset while a branch is held in WAIT
        issue_n(1);
        i_br_valid = 1'b1; i_br_insn = 16'h0E00; i_br_pc = 16'h1234;
        tick();
        i_br_valid = 1'b0;
        chk("wait_ready", 16'(o_br_ready), 16'h0000);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_nzp", 16'(o_nzp), 16'h0002);
        chk("midrst_pending", 16'(o_pending), 16'h0000);
        chk("midrst_ready", 16'(o_br_ready), 16'h0001);
        tick();
        rst_n = 1'b1;
        nzp_m = 2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_nopulse", 16'(o_redirect_valid), 16'h0000);
        end

        // BRn taken after a negative result
        issue_n(1);
        wb(16'h8000);
        chk("nzp_neg", 16'(o_nzp), 16'h0004);
        i_br_valid = 1'b1; i_br_insn = 16'h0805; i_br_pc = 16'h0100;
        tick();
        i_br_valid = 1'b0;
        chk("brn_pc_const", o_redirect_pc, 16'h0106);
        check_redirect("brn", 16'h0805, 16'h0100);
        tick();
        chk("brn_idle", 16'(o_br_ready), 16'h0001);
        chk("brn_pulse_end", 16'(o_redirect_valid), 16'h0000);

        // BRp not taken after zero, PC+1 wraps
        issue_n(1);
        wb(16'h0000);
        i_br_valid = 1'b1; i_br_insn = 16'h0203; i_br_pc = 16'hFFFF;
        tick();
        i_br_valid = 1'b0;
        chk("brp_pc_const", o_redirect_pc, 16'h0000);
        check_redirect("brp", 16'h0203, 16'hFFFF);
        tick();

        // Branch stalls until both in-flight writers complete
        issue_n(2);
        chk("pend2", 16'(o_pending), 16'h0002);
        i_br_valid = 1'b1; i_br_insn = 16'h0404; i_br_pc = 16'h0200;
        tick();
        i_br_valid = 1'b0;
        chk("brz_wait_rv", 16'(o_redirect_valid), 16'h0000);
        chk("brz_wait_ready", 16'(o_br_ready), 16'h0000);
        wb(16'h0005);
        chk("brz_wait2_rv", 16'(o_redirect_valid), 16'h0000);
        chk("pend1", 16'(o_pending), 16'h0001);
        wb(16'h0000);
        chk("brz_taken_const", 16'(o_redirect_taken), 16'h0001);
        check_redirect("brz", 16'h0404, 16'h0200);
        tick();

        // Issue and writeback together, then underflow
        issue_n(1);
        i_issue_valid = 1'b1;
        wb(16'h0007);
        i_issue_valid = 1'b0;
        chk("same_cycle_pend", 16'(o_pending), 16'h0001);
        chk("no_err_yet", 16'(o_err), 16'h0000);
        wb(16'h0001);
        chk("pend0", 16'(o_pending), 16'h0000);
        wb(16'h0001);
        chk("underflow_pend", 16'(o_pending), 16'h0000);
        chk("underflow_err", 16'(o_err), 16'h0001);
        tick();
        chk("err_sticky", 16'(o_err), 16'h0001);

        // Fill to the limit, then one more issue is ignored
        issue_n(7);
        chk("full_pend", 16'(o_pending), 16'h0007);
        chk("full_stall", 16'(o_issue_stall), 16'h0001);
        issue_n(1);
        chk("overflow_pend", 16'(o_pending), 16'h0007);
        for (int i = 0; i < 7; i++) wb(16'h0042);
        chk("drained_pend", 16'(o_pending), 16'h0000);
        chk("drained_stall", 16'(o_issue_stall), 16'h0000);
`ifdef LC4_BR_STATS_EN
        chk("stat_resolved_dir", o_stat_resolved, 16'd3);
        chk("stat_taken_dir", o_stat_taken, 16'd2);
`endif

        // Randomized branches against the model; the first writeback coincides with accept
        do_reset();
        for (int it = 0; it < 60; it++) begin
            k = $urandom_range(0, 3);
            issue_n(k);
            insn = 16'($urandom);
            if ($urandom_range(0, 1) == 1) insn[15:12] = 4'h0;
            pc = 16'($urandom);
            r = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            i_br_valid = 1'b1; i_br_insn = insn; i_br_pc = pc;
            if (k > 0) begin
                i_wb_valid = 1'b1; i_wb_nzp_we = 1'b1; i_wb_result = r;
            end
            tick();
            i_br_valid = 1'b0; i_wb_valid = 1'b0; i_wb_nzp_we = 1'b0;
            if (k > 0) nzp_m = nzp_of(int'(r));
            if (k <= 1) begin
                check_redirect("rnd", insn, pc);
            end else begin
                chk("rnd_wait_rv", 16'(o_redirect_valid), 16'h0000);
                for (int j = 1; j < k; j++) begin
                    r = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
                    wb(r);
                    if (j < k - 1)
                        chk("rnd_wait_rv", 16'(o_redirect_valid), 16'h0000);
                    else
                        check_redirect("rnd", insn, pc);
                end
            end
            tick();
            chk("rnd_ready", 16'(o_br_ready), 16'h0001);
            chk("rnd_nzp", 16'(o_nzp), 16'(nzp_m));
        end
        chk("rnd_err", 16'(o_err), 16'h0000);
        chk("rnd_pend", 16'(o_pending), 16'h0000);
`ifdef LC4_BR_STATS_EN
        chk("stat_resolved_rnd", o_stat_resolved, 16'(exp_resolved));
        chk("stat_taken_rnd", o_stat_taken, 16'(exp_taken));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
